// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller slice.
//   op_e    : instruction opcodes carried on in_op
//   ALU_*   : opALU codes understood by the downstream 16-bit ALU
//   state_e : controller sequencing states
//   alu_code: opcode -> opALU translation
package alu_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_XOR   = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_LOADI = 2'b11
    } op_e;

    localparam logic [1:0] ALU_XOR = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10,
        RESP = 2'b11
    } state_e;

    // Settle counter width; covers SETTLE_CYCLES up to 15.
    localparam int unsigned CNT_W = 4;

    function automatic logic [1:0] alu_code(input op_e op);
        logic [1:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            default: code = ALU_XOR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// General register file for the ALU issue controller.
// RF_DEPTH x WIDTH storage, two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear.
//   clk, rst_n         : clock / async clear
//   we_i, waddr_i,
//   wdata_i            : write port (captured on rising edge)
//   raddr1_i/rdata1_o  : read port 1
//   raddr2_i/rdata2_o  : read port 2
module alu_regfile #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned RF_DEPTH = 4,
    localparam int unsigned IDX_W   = $clog2(RF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr1_i,
    input  logic [IDX_W-1:0] raddr2_i,
    output logic [WIDTH-1:0] rdata1_o,
    output logic [WIDTH-1:0] rdata2_o
);

    logic [WIDTH-1:0] mem_q [RF_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencer in front of the 16-bit ripple ALU.
// Accepts one instruction over in_valid/in_ready, drives the ALU operands and
// opALU code for SETTLE_CYCLES cycles, captures the result, writes it back to
// the register file and offers it downstream over out_valid/out_ready.
//   clk, rst_n                       : clock, async active-low reset
//   in_valid/in_ready                : instruction handshake
//   in_op, in_rd, in_rs1, in_rs2,
//   in_imm                           : instruction fields
//   alu_a, alu_b, alu_op             : registered ALU operands / opALU
//   alu_r                            : ALU result (carry bit ignored)
//   out_valid/out_ready              : result handshake
//   out_data, out_rd, out_zero       : result value, destination, zero flag
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned RF_DEPTH      = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    localparam int unsigned IDX_W        = $clog2(RF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [IDX_W-1:0] in_rd,
    input  logic [IDX_W-1:0] in_rs1,
    input  logic [IDX_W-1:0] in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH:0]   alu_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_rd,
    output logic             out_zero
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [IDX_W-1:0]   rd_q,       rd_d;
    logic [WIDTH-1:0]   alu_a_q,    alu_a_d;
    logic [WIDTH-1:0]   alu_b_q,    alu_b_d;
    logic [1:0]         alu_op_q,   alu_op_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]   out_rd_q,   out_rd_d;
    logic               out_zero_q, out_zero_d;

    logic               rf_we;
    logic [IDX_W-1:0]   rf_waddr;
    logic [WIDTH-1:0]   rf_wdata;
    logic [WIDTH-1:0]   rf_rd1;
    logic [WIDTH-1:0]   rf_rd2;

    logic               unused_carry;
    assign unused_carry = alu_r[WIDTH];

    // Operands are read straight from the incoming indices on the accept edge,
    // so rs1/rs2/op need no holding registers; only rd survives to writeback.
    alu_regfile #(
        .WIDTH    (WIDTH),
        .RF_DEPTH (RF_DEPTH)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (rf_wdata),
        .raddr1_i (in_rs1),
        .raddr2_i (in_rs2),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= ALU_XOR;
            out_data_q <= '0;
            out_rd_q   <= '0;
            out_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            out_data_q <= out_data_d;
            out_rd_q   <= out_rd_d;
            out_zero_q <= out_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        out_data_d = out_data_q;
        out_rd_d   = out_rd_q;
        out_zero_d = out_zero_q;
        rf_we      = 1'b0;
        rf_waddr   = rd_q;
        rf_wdata   = out_data_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rd_d = in_rd;
                    if (op_e'(in_op) == OP_LOADI) begin
                        rf_we      = 1'b1;
                        rf_waddr   = in_rd;
                        rf_wdata   = in_imm;
                        out_data_d = in_imm;
                        out_rd_d   = in_rd;
                        out_zero_d = (in_imm == '0);
                        state_d    = RESP;
                    end else begin
                        alu_a_d  = rf_rd1;
                        alu_b_d  = rf_rd2;
                        alu_op_d = alu_code(op_e'(in_op));
                        cnt_d    = CNT_LOAD;
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                // The result is captured on the edge leaving EXEC, while the
                // opALU code is still applied; WB then only writes it back.
                if (cnt_q == '0) begin
                    out_data_d = alu_r[WIDTH-1:0];
                    out_rd_d   = rd_q;
                    out_zero_d = (alu_r[WIDTH-1:0] == '0);
                    alu_op_d   = ALU_XOR;
                    state_d    = WB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WB: begin
                rf_we   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: driver pushes expected results from a
// register-array model, monitor compares whenever out_valid is high.
module tb_alu_issue_ctrl;

    localparam int unsigned W = 16;
    localparam int unsigned S = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b00;
    logic [1:0]    in_rd = 2'b00;
    logic [1:0]    in_rs1 = 2'b00;
    logic [1:0]    in_rs2 = 2'b00;
    logic [W-1:0]  in_imm = '0;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [1:0]    alu_op;
    logic [W:0]    alu_r;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [1:0]    out_rd;
    logic          out_zero;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   rd;
        logic         zero;
    } exp_t;

    exp_t          sb_q[$];
    logic [W-1:0]  rf_m [4];
    int            checks = 0;
    int            errors = 0;
    bit            hold = 1'b0;
    bit            rnd  = 1'b0;

    alu_issue_ctrl #(
        .WIDTH         (W),
        .RF_DEPTH      (4),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_r     (alu_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Environment model of the ALU itself.
    always_comb begin
        case (alu_op)
            2'b00:   alu_r = {1'b0, alu_a ^ alu_b};
            2'b01:   alu_r = {1'b0, alu_a} + {1'b0, alu_b};
            2'b11:   alu_r = {1'b0, alu_a} - {1'b0, alu_b};
            default: alu_r = '0;
        endcase
    end

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: out_valid with data 0x%0h, no result expected", out_data);
            end else begin
                check("out_data", out_data, sb_q[0].data);
                check("out_rd",   out_rd,   sb_q[0].rd);
                check("out_zero", out_zero, sb_q[0].zero);
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    // Present an instruction from a negedge, wait for acceptance, update the
    // model and return at the negedge just after the accept edge.
    task automatic accept_only(input logic [1:0] op, input logic [1:0] rd,
                               input logic [1:0] rs1, input logic [1:0] rs2,
                               input logic [W-1:0] imm,
                               output logic [W-1:0] a_exp, output logic [W-1:0] b_exp);
        int t = 0;
        logic [W-1:0] res;
        exp_t e;
        in_valid = 1'b1;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t);
        end
        @(posedge clk);
        a_exp = rf_m[rs1];
        b_exp = rf_m[rs2];
        case (op)
            2'b00:   res = a_exp ^ b_exp;
            2'b01:   res = a_exp + b_exp;
            2'b10:   res = a_exp - b_exp;
            default: res = imm;
        endcase
        rf_m[rd] = res;
        e.data = res; e.rd = rd; e.zero = (res == 0);
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_op = 2'($urandom); in_rd = 2'($urandom); in_imm = W'($urandom);
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [W-1:0] imm);
        logic [W-1:0] a_exp, b_exp;
        int n = 0;
        int unsigned lat_exp;
        logic [1:0] code;
        accept_only(op, rd, rs1, rs2, imm, a_exp, b_exp);
        code    = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b11 : 2'b00;
        lat_exp = (op == 2'b11) ? 1 : S + 2;
        check("alu_op_exec", alu_op, code);
        if (op != 2'b11) begin
            check("alu_a", alu_a, a_exp);
            check("alu_b", alu_b, b_exp);
        end
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", n + 1, lat_exp);
        check("alu_op_idle", alu_op, 0);
        check("in_ready_resp", in_ready, 0);
    endtask

    initial begin
        logic [W-1:0] a_x, b_x;
        int t;
        for (int i = 0; i < 4; i++) rf_m[i] = '0;

        #12;
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_op",    alu_op,    0);
        check("rst_alu_a",     alu_a,     0);
        check("rst_out_data",  out_data,  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        issue(2'b11, 2'd0, 2'd0, 2'd0, 16'h1234);
        issue(2'b11, 2'd1, 2'd0, 2'd0, 16'h00FF);
        issue(2'b11, 2'd2, 2'd0, 2'd0, 16'h0F0F);
        issue(2'b01, 2'd3, 2'd1, 2'd2, 16'h0);       // 0x100E
        issue(2'b11, 2'd1, 2'd0, 2'd0, 16'h0000);
        issue(2'b11, 2'd2, 2'd0, 2'd0, 16'h0001);
        issue(2'b10, 2'd0, 2'd1, 2'd2, 16'h0);       // 0xFFFF
        issue(2'b00, 2'd2, 2'd2, 2'd2, 16'h0);       // 0, zero flag
        issue(2'b01, 2'd0, 2'd2, 2'd3, 16'h0);       // 0 + 0x100E

        // Backpressure: result must be held while a new instruction waits.
        hold = 1'b1;
        issue(2'b11, 2'd1, 2'd0, 2'd0, 16'hBEEF);
        in_valid = 1'b1; in_op = 2'b01; in_rd = 2'd2; in_rs1 = 2'd1; in_rs2 = 2'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready",  in_ready,  0);
            check("bp_out_valid", out_valid, 1);
        end
        hold = 1'b0;
        issue(2'b01, 2'd2, 2'd1, 2'd1, 16'h0);       // 0x7DDE

        // Randomised traffic with random downstream stalls.
        rnd = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] imm;
            imm = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            issue(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), imm);
        end
        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb_q.size(), 0);
        rnd = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of an ALU operation.
        issue(2'b11, 2'd1, 2'd0, 2'd0, 16'h0005);
        issue(2'b11, 2'd2, 2'd0, 2'd0, 16'h0007);
        accept_only(2'b01, 2'd3, 2'd1, 2'd2, 16'h0, a_x, b_x);
        check("pre_rst_alu_op", alu_op, 1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        for (int i = 0; i < 4; i++) rf_m[i] = '0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_alu_op",    alu_op,    0);
        check("mid_rst_in_ready",  in_ready,  0);
        check("mid_rst_alu_a",     alu_a,     0);
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b01, 2'd0, 2'd3, 2'd3, 16'h0);       // r3 cleared -> 0
        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("final_drain", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencer directly upstream of the 16-bit ALU (ops: add, sub, xor).
- Accepts one instruction at a time over a valid/ready handshake and holds a small register file.
- Drives the ALU operands A and B and the 2-bit opALU code, waits a programmable settle time for the ripple adder, then captures the ALU result.
- Writes the result back to the register file and presents it downstream over a valid/ready handshake.

Parameters:
- WIDTH, 16: datapath width; must match the ALU operand width.
- RF_DEPTH, 4: number of general registers; register index width is clog2(RF_DEPTH).
- SETTLE_CYCLES, 2: number of cycles the operands are held stable before capture; legal range 1..15.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, asynchronous assert, active-low.
- in_valid  in  1: instruction valid.
- in_ready  out  1: controller can accept an instruction.
- in_op  in  2: 00 XOR, 01 ADD, 10 SUB, 11 LOADI.
- in_rd  in  2: destination register index.
- in_rs1  in  2: source register 1 index (drives ALU A).
- in_rs2  in  2: source register 2 index (drives ALU B).
- in_imm  in  WIDTH: immediate value, used by LOADI only.
- alu_a  out  WIDTH: ALU operand A.
- alu_b  out  WIDTH: ALU operand B.
- alu_op  out  2: ALU opALU code.
- alu_r  in  WIDTH+1: ALU result; bit WIDTH is ignored.
- out_valid  out  1: result valid.
- out_ready  in  1: downstream accepts the result.
- out_data  out  WIDTH: result value.
- out_rd  out  2: register the result was written to.
- out_zero  out  1: out_data == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE; all registers, alu_a, alu_b, out_data and out_rd are 0.
  - alu_op is 2'b00; out_valid and out_zero are 0; in_ready is 0 while rst_n is low.
  - Reset mid-operation abandons the instruction with no writeback.
- ALU opALU mapping (in_op to alu_op):
  - ADD maps to 2'b01, SUB to 2'b11, XOR to 2'b00.
  - In every state other than EXEC, alu_op is 2'b00 and alu_a/alu_b hold their last values.
- States:
  - IDLE: in_ready=1. On in_valid, latch op, rd, rs1, rs2 and imm. For LOADI, write rf[rd]=imm, set out_data=imm, go to RESP. Otherwise go to EXEC.
  - EXEC: on entry, register alu_a=rf[rs1], alu_b=rf[rs2] and alu_op. The settle counter loads SETTLE_CYCLES-1 and decrements each cycle. Go to WB when the counter is 0.
  - WB: out_data=alu_r[WIDTH-1:0], rf[rd]=alu_r[WIDTH-1:0], out_rd=rd, out_zero=(result==0). Go to RESP.
  - RESP: out_valid=1, with out_data, out_rd and out_zero held stable. On out_ready, go to IDLE, deasserting out_valid on the following edge.
- Latency:
  - ALU op, from the accept edge to out_valid high: SETTLE_CYCLES+2 cycles (4 at the default).
  - LOADI: 1 cycle.
  - Throughput: one instruction per SETTLE_CYCLES+3 cycles with out_ready tied high. No pipelining, no back-to-back accept.
- Arithmetic:
  - Modulo 2^WIDTH; SUB wraps, so 0-1 gives 0xFFFF.
  - Carry out (bit WIDTH) is discarded.
- Hazards:
  - rd equal to rs1 or rs2 is legal. Operands are sampled at EXEC entry, so the old value is used and the write lands in WB.
  - rs1 == rs2 is legal: XOR gives 0, SUB gives 0.
- Handshake rules:
  - in_valid while in_ready=0 is ignored; the upstream holds the instruction.
  - out_ready asserted while out_valid=0 has no effect.
  - A backpressured result is held indefinitely.

Decomposition:
- Shared package constants:
  - opcode encodings OP_XOR, OP_ADD, OP_SUB, OP_LOADI;
  - ALU code constants ALU_XOR=2'b00, ALU_ADD=2'b01, ALU_SUB=2'b11;
  - state encoding IDLE, EXEC, WB, RESP.
- One natural sub-module: alu_regfile, an RF_DEPTH x WIDTH array with 2 asynchronous read ports, 1 synchronous write port and asynchronous clear.
- The FSM, settle counter and output registers stay in alu_issue_ctrl.

Test Plan:
- Reset then LOADI r0=0x1234 -> out_valid 1 cycle after accept; out_data=0x1234, out_rd=0, out_zero=0.
- LOADI r1=0x00FF, r2=0x0F0F; ADD r3=r1+r2 -> alu_op=01 during EXEC; out_data=0x100E 4 cycles after accept; r3=0x100E.
- LOADI r1=0x0000, r2=0x0001; SUB r0=r1-r2 -> alu_op=11; out_data=0xFFFF; carry ignored.
- XOR r2=r2^r2 (rd==rs) -> out_data=0, out_zero=1; a later ADD using r2 sees 0.
- Hold out_ready=0 for 10 cycles with in_valid high -> out_valid and out_data stable, in_ready=0, no new accept; release -> IDLE and next accept.
- Assert rst_n low during EXEC of ADD r3 -> out_valid stays 0, r3 reads 0 after reset, alu_op=00.
